score_digit_sequencer: RTL and testbench
========================================

Name: score_digit_sequencer

Overview:
Multi-cycle binary-to-BCD converter and sequencer for the score and high-score overlay in the VGA controller. On each frame boundary (screenEnd) it latches score and high_score. It converts both values in turn through one shared shift-add-3 (double-dabble) datapath. It then publishes two registered 3-digit BCD words that stay stable for the whole next frame, so the sprite-address logic needs no per-pixel divide or modulo.

Parameters:
DIGITS, 3, number of BCD digits per value
BIN_BITS, 10, width of the clamped binary value and the shift count per conversion (2^10 > 999)
MAX_VALUE, 999, saturation ceiling; must equal 10^DIGITS - 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
frame_start  in  1  conversion request; driven from screenEnd
score  in  32  current score, signed integer
high_score  in  32  current high score, signed integer
score_digits  out  4*DIGITS  BCD digits; [11:8] hundreds, [7:4] tens, [3:0] ones
high_score_digits  out  4*DIGITS  BCD digits, same layout
busy  out  1  high whenever the state is not IDLE
digits_valid  out  1  one-cycle pulse when both digit words update together
dropped_start  out  1  one-cycle pulse when frame_start arrives while not IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including digit words, busy, digits_valid and dropped_start.
  - Shift counter and work registers are cleared.
- Clamp on latch:
  - Negative value (bit 31 = 1) becomes 0.
  - Value greater than MAX_VALUE becomes MAX_VALUE.
  - Otherwise the value is taken as is, truncated to BIN_BITS.
- State machine: IDLE -> CONV_S -> CONV_H -> COMMIT -> IDLE.
  - IDLE: if frame_start = 1 at edge E0, latch both clamped inputs, clear the BCD accumulator and counter, go to CONV_S. Otherwise stay in IDLE.
  - CONV_S: one dabble step per cycle on the score value, for BIN_BITS cycles (edges E1..E10). On the last step, store the BCD result in an internal hold register, reset the accumulator and counter, go to CONV_H.
  - CONV_H: the same BIN_BITS steps on the high-score value (edges E11..E20), then go to COMMIT.
  - COMMIT (edge E21): load score_digits and high_score_digits from the finished results in the same edge, drive digits_valid = 1 for this one cycle, return to IDLE.
- Dabble step, one iteration:
  - For each BCD nibble, if nibble >= 5, add 3 (4-bit add, no carry out of the nibble).
  - Then shift {bcd, bin} left by 1; the binary MSB enters the BCD LSB.
- Timing:
  - Latency is fixed: outputs change on the 21st rising edge after the accepting edge.
  - Throughput is at most one conversion per 22 cycles, far below the frame rate.
- Input changes while busy are ignored, because the values were latched at E0.
- frame_start high in any non-IDLE state, including COMMIT:
  - The request is ignored.
  - dropped_start pulses on the following cycle.
  - The conversion in progress completes unaffected.
- frame_start held high continuously: it is accepted again in the first IDLE cycle after COMMIT.
- Reset mid-conversion: outputs clear immediately and no digits_valid pulse is issued. The next frame_start after reset release starts a clean conversion.
- Digit outputs hold their last committed value indefinitely between commits.

Decomposition:
- Shared package (vga_pkg) holds:
  - DIGITS, BIN_BITS and MAX_VALUE localparams;
  - the state encoding (IDLE=2'd0, CONV_S=2'd1, CONV_H=2'd2, COMMIT=2'd3);
  - the BCD word width constant (4*DIGITS).
- Sub-module bcd_dabble_step: purely combinational, one iteration. Inputs are bcd[4*DIGITS-1:0] and bin[BIN_BITS-1:0]; outputs are the next bcd and next bin. It is instantiated once and time-shared by CONV_S and CONV_H.

Test Plan:
- Reset: hold reset low, toggle clk and frame_start -> both digit words 12'h000; busy, digits_valid and dropped_start all 0.
- Basic conversion: score=123, high_score=987, one-cycle frame_start -> busy high from E1 to E21; at E21 score_digits=12'h123, high_score_digits=12'h987, and digits_valid high for exactly one cycle.
- Saturation and negative inputs:
  - score=1500, high_score=999 -> 12'h999, 12'h999.
  - score=32'hFFFF_FFFF, high_score=0 -> 12'h000, 12'h000.
  - score=5, high_score=50 -> 12'h005, 12'h050.
- Input change and dropped start: change score from 42 to 77 at E5, and pulse frame_start at E8 -> commit shows 12'h042; dropped_start pulses at E9; no second conversion starts.
- Reset mid-conversion: assert reset at E6 of a conversion of 321/654 -> digits 0 immediately and no digits_valid. After release, convert 321/654 -> 12'h321/12'h654.
- Back-to-back: hold frame_start high for 60 cycles -> digits_valid pulses every 22 cycles, and dropped_start pulses on each non-IDLE cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and input clamp for the score digit sequencer.
package vga_pkg;

   localparam int DIGITS    = 3;
   localparam int BIN_BITS  = 10;
   localparam int MAX_VALUE = 999;
   localparam int BCD_W     = 4 * DIGITS;
   localparam int CNT_W     = $clog2(BIN_BITS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV_S = 2'd1,
      CONV_H = 2'd2,
      COMMIT = 2'd3
   } seq_state_e;

   // Negative values read as zero, anything above the display range saturates.
   function automatic logic [BIN_BITS-1:0] clamp_value(input logic [31:0] value);
      logic [BIN_BITS-1:0] result;
      if (value[31]) begin
         result = '0;
      end else if (value > 32'(MAX_VALUE)) begin
         result = BIN_BITS'(MAX_VALUE);
      end else begin
         result = value[BIN_BITS-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational shift-add-3 iteration of the binary-to-BCD conversion.
module bcd_dabble_step
   import vga_pkg::*;
(
   input  logic [BCD_W-1:0]    bcd,
   input  logic [BIN_BITS-1:0] bin,
   output logic [BCD_W-1:0]    bcd_next,
   output logic [BIN_BITS-1:0] bin_next
);

   logic [BCD_W-1:0]          adj_s;
   logic [BCD_W+BIN_BITS-1:0] shifted_s;

   // Add 3 to every nibble that would overflow past 9 after the shift.
   always_comb begin
      adj_s = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = bcd[4*i +: 4];
         end
      end
   end

   // Shift the combined word left; the binary MSB enters the BCD LSB.
   always_comb begin
      shifted_s = {adj_s, bin} << 1;
      bcd_next  = shifted_s[BCD_W+BIN_BITS-1:BIN_BITS];
      bin_next  = shifted_s[BIN_BITS-1:0];
   end

endmodule

// File: rtl/score_digit_sequencer.sv
// Latches score/high score at the frame boundary, converts both through one
// shared double-dabble step, and publishes both BCD words together.
module score_digit_sequencer
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic [31:0]      score,
   input  logic [31:0]      high_score,
   output logic [BCD_W-1:0] score_digits,
   output logic [BCD_W-1:0] high_score_digits,
   output logic             busy,
   output logic             digits_valid,
   output logic             dropped_start
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_BITS - 1);

   seq_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [BIN_BITS-1:0] bin_q, bin_d;
   logic [BIN_BITS-1:0] hi_bin_q, hi_bin_d;
   logic [BCD_W-1:0]    hold_q, hold_d;
   logic [BCD_W-1:0]    score_digits_q, score_digits_d;
   logic [BCD_W-1:0]    high_digits_q, high_digits_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                dropped_q, dropped_d;

   logic [BCD_W-1:0]    step_bcd_s;
   logic [BIN_BITS-1:0] step_bin_s;

   bcd_dabble_step u_step (
      .bcd      (bcd_q),
      .bin      (bin_q),
      .bcd_next (step_bcd_s),
      .bin_next (step_bin_s)
   );

   // Next-state and datapath control for the latch/convert/convert/commit sequence.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bcd_d          = bcd_q;
      bin_d          = bin_q;
      hi_bin_d       = hi_bin_q;
      hold_d         = hold_q;
      score_digits_d = score_digits_q;
      high_digits_d  = high_digits_q;
      valid_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               bin_d    = clamp_value(score);
               hi_bin_d = clamp_value(high_score);
               bcd_d    = '0;
               cnt_d    = '0;
               state_d  = CONV_S;
            end else begin
               state_d  = IDLE;
            end
         end
         CONV_S: begin
            if (cnt_q == LAST_STEP) begin
               // Park the score result and restart the datapath on the high score.
               hold_d  = step_bcd_s;
               bcd_d   = '0;
               bin_d   = hi_bin_q;
               cnt_d   = '0;
               state_d = CONV_H;
            end else begin
               bcd_d   = step_bcd_s;
               bin_d   = step_bin_s;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         CONV_H: begin
            bcd_d = step_bcd_s;
            bin_d = step_bin_s;
            if (cnt_q == LAST_STEP) begin
               cnt_d   = '0;
               state_d = COMMIT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         COMMIT: begin
            score_digits_d = hold_q;
            high_digits_d  = bcd_q;
            valid_d        = 1'b1;
            state_d        = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d    = (state_d != IDLE);
      dropped_d = frame_start && (state_q != IDLE);
   end

   // State, work registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         bcd_q          <= '0;
         bin_q          <= '0;
         hi_bin_q       <= '0;
         hold_q         <= '0;
         score_digits_q <= '0;
         high_digits_q  <= '0;
         busy_q         <= 1'b0;
         valid_q        <= 1'b0;
         dropped_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bcd_q          <= bcd_d;
         bin_q          <= bin_d;
         hi_bin_q       <= hi_bin_d;
         hold_q         <= hold_d;
         score_digits_q <= score_digits_d;
         high_digits_q  <= high_digits_d;
         busy_q         <= busy_d;
         valid_q        <= valid_d;
         dropped_q      <= dropped_d;
      end
   end

   assign score_digits      = score_digits_q;
   assign high_score_digits = high_digits_q;
   assign busy              = busy_q;
   assign digits_valid      = valid_q;
   assign dropped_start     = dropped_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Self-checking bench for score_digit_sequencer against a decimal reference model.
module tb_score_digit_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [31:0] score = 32'd0;
   logic [31:0] high_score = 32'd0;
   logic [11:0] score_digits;
   logic [11:0] high_score_digits;
   logic        busy;
   logic        digits_valid;
   logic        dropped_start;

   int checks = 0;
   int errors = 0;

   score_digit_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .frame_start       (frame_start),
      .score             (score),
      .high_score        (high_score),
      .score_digits      (score_digits),
      .high_score_digits (high_score_digits),
      .busy              (busy),
      .digits_valid      (digits_valid),
      .dropped_start     (dropped_start)
   );

   always #5 clk = ~clk;

   // Reference: clamp as a signed integer, then split into decimal digits.
   function automatic logic [11:0] exp_bcd(input logic [31:0] v);
      int x;
      logic [3:0] h, t, o;
      x = $signed(v);
      if (x < 0) x = 0;
      else if (x > 999) x = 999;
      h = 4'(x / 100);
      t = 4'((x / 10) % 10);
      o = 4'(x % 10);
      return {h, t, o};
   endfunction

   // Stimulus driver: one-cycle frame_start, then wait (bounded) for digits_valid.
   // lat is the number of edges after the accepting edge, -1 on timeout.
   task automatic start_and_wait(input logic [31:0] s, input logic [31:0] h,
                                 output int lat, output int busy_low);
      score = s;
      high_score = h;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      lat = -1;
      busy_low = 0;
      for (int k = 0; k < 40; k++) begin
         if (digits_valid) begin
            lat = k;
            break;
         end
         if (!busy) busy_low++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) frame_start = ~frame_start;
      end
      frame_start = 1'b0;
      @(negedge clk);
      checks++;
      if ({score_digits, high_score_digits} !== 24'h000000) begin
         errors++;
         $display("FAIL reset_digits: got %h/%h want 000/000", score_digits, high_score_digits);
      end
      checks++;
      if ({busy, digits_valid, dropped_start} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got busy/valid/dropped=%b want 000", {busy, digits_valid, dropped_start});
      end
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_and_check(input string name, input logic [31:0] s, input logic [31:0] h);
      int lat, busy_low;
      start_and_wait(s, h, lat, busy_low);
      checks++;
      if (lat !== 21) begin
         errors++;
         $display("FAIL %s_latency: got %0d want 21", name, lat);
      end
      checks++;
      if (score_digits !== exp_bcd(s)) begin
         errors++;
         $display("FAIL %s_score: got %h want %h (in %0d)", name, score_digits, exp_bcd(s), $signed(s));
      end
      checks++;
      if (high_score_digits !== exp_bcd(h)) begin
         errors++;
         $display("FAIL %s_high: got %h want %h (in %0d)", name, high_score_digits, exp_bcd(h), $signed(h));
      end
      checks++;
      if (busy_low !== 0) begin
         errors++;
         $display("FAIL %s_busy: busy low %0d cycles during conversion, want 0", name, busy_low);
      end
      @(negedge clk);
      checks++;
      if ({digits_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s_pulse_end: got valid/busy=%b want 00", name, {digits_valid, busy});
      end
   endtask

   task automatic test_basic();
      run_and_check("basic", 32'd123, 32'd987);
   endtask

   task automatic test_saturation();
      run_and_check("sat_high", 32'd1500, 32'd999);
      run_and_check("negative", 32'hFFFF_FFFF, 32'd0);
      run_and_check("small", 32'd5, 32'd50);
      run_and_check("edge_1000", 32'd1000, 32'h8000_0000);
   endtask

   task automatic test_random();
      logic [31:0] s, h;
      for (int n = 0; n < 8; n++) begin
         s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         h = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         run_and_check("random", s, h);
      end
   endtask

   task automatic test_input_change_dropped();
      int valid_at, extra;
      score = 32'd42;
      high_score = 32'd600;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      valid_at = -1;
      for (int k = 0; k < 40; k++) begin
         if (k == 5) score = 32'd77;
         if (k == 7) frame_start = 1'b1;
         if (k == 8) begin
            frame_start = 1'b0;
            checks++;
            if (dropped_start !== 1'b1) begin
               errors++;
               $display("FAIL dropped_pulse: got %b want 1", dropped_start);
            end
         end
         if (k == 9) begin
            checks++;
            if (dropped_start !== 1'b0) begin
               errors++;
               $display("FAIL dropped_single: got %b want 0", dropped_start);
            end
         end
         if (digits_valid) begin
            valid_at = k;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (valid_at !== 21) begin
         errors++;
         $display("FAIL dropped_latency: got %0d want 21", valid_at);
      end
      checks++;
      if ({score_digits, high_score_digits} !== {exp_bcd(32'd42), exp_bcd(32'd600)}) begin
         errors++;
         $display("FAIL dropped_digits: got %h/%h want 042/600", score_digits, high_score_digits);
      end
      extra = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (busy || digits_valid) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL dropped_no_restart: got %0d busy/valid cycles want 0", extra);
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      score = 32'd321;
      high_score = 32'd654;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({score_digits, high_score_digits, busy, digits_valid} !== 26'd0) begin
         errors++;
         $display("FAIL midreset_clear: got %h/%h busy=%b valid=%b want all 0",
                  score_digits, high_score_digits, busy, digits_valid);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      stray = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (digits_valid || busy) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL midreset_no_valid: got %0d busy/valid cycles want 0", stray);
      end
      run_and_check("after_reset", 32'd321, 32'd654);
   endtask

   task automatic test_back_to_back();
      int bad_valid, bad_drop, bad_busy, pulses;
      logic [31:0] s, h;
      s = 32'($urandom_range(0, 999));
      h = 32'($urandom_range(0, 999));
      score = s;
      high_score = h;
      bad_valid = 0;
      bad_drop = 0;
      bad_busy = 0;
      pulses = 0;
      @(negedge clk) frame_start = 1'b1;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (digits_valid) pulses++;
         if (digits_valid !== ((j % 22) == 21)) bad_valid++;
         if (dropped_start !== ((j % 22) != 0)) bad_drop++;
         if (busy !== ((j % 22) != 21)) bad_busy++;
      end
      frame_start = 1'b0;
      checks++;
      if (bad_valid !== 0 || pulses !== 2) begin
         errors++;
         $display("FAIL b2b_valid: %0d wrong cycles, %0d pulses, want 0 wrong and 2 pulses", bad_valid, pulses);
      end
      checks++;
      if (bad_drop !== 0) begin
         errors++;
         $display("FAIL b2b_dropped: got %0d wrong cycles want 0", bad_drop);
      end
      checks++;
      if (bad_busy !== 0) begin
         errors++;
         $display("FAIL b2b_busy: got %0d wrong cycles want 0", bad_busy);
      end
      checks++;
      if ({score_digits, high_score_digits} !== {exp_bcd(s), exp_bcd(h)}) begin
         errors++;
         $display("FAIL b2b_digits: got %h/%h want %h/%h", score_digits, high_score_digits, exp_bcd(s), exp_bcd(h));
      end
      repeat (30) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_random();
      test_input_change_dropped();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
